// File: rtl/commit_mon.sv
// commit_mon: per-hart commit monitor emitting timestamped graduation/exception/hang records through a FIFO
module commit_mon #(
  parameter int W = 2,
  parameter int D = 8,
  parameter int H = 0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [31:0]     cfg_hang,
  input  logic [4:0]      cfg_grad,
  input  logic [63:0]     cfg_xmask,
  input  logic [W-1:0]    cmt_vld,
  input  logic [W*64-1:0] cmt_pc,
  input  logic [W*32-1:0] cmt_instr,
  input  logic            wfi,
  input  logic            expt_vld,
  input  logic [63:0]     expt_cause,
  input  logic [63:0]     expt_pc,
  input  logic [31:0]     expt_instr,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [1:0]      ev_type,
  output logic [7:0]      ev_hart,
  output logic [63:0]     ev_time,
  output logic [63:0]     ev_pc,
  output logic [63:0]     ev_data,
  output logic            hang_o,
  output logic [31:0]     drop_cnt
);
  localparam int AW = $clog2(D);
  typedef struct packed {
    logic [1:0]  t;
    logic [63:0] tm;
    logic [63:0] pc;
    logic [63:0] data;
  } rec_t;
  rec_t mem [D];
  rec_t win_rec;
  logic [63:0] cyc_q, last_pc_q, gpc, lpc;
  logic [31:0] hang_cnt_q, grad_cnt_q, last_instr_q, ginstr, linstr, k, mask;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [32:0] dsum;
  logic [1:0] ndrop;
  logic act, hang_c, expt_c, grad_c, win, push, pop, unused_instr;
  assign unused_instr = ^expt_instr;
  assign act = |cmt_vld | wfi;
  assign mask = (32'd1 << cfg_grad) - 32'd1;
  assign hang_c = ~act & (cfg_hang != 32'd0) & (hang_cnt_q == cfg_hang);
  assign expt_c = expt_vld & ~((expt_cause[63:6] == '0) & cfg_xmask[expt_cause[5:0]]);
  assign win = hang_c | expt_c | grad_c;
  assign push = win & ~cnt_q[AW];
  assign ev_valid = cnt_q != '0;
  assign pop = ev_valid & ev_ready;
  assign ndrop = {1'b0, hang_c} + {1'b0, expt_c} + {1'b0, grad_c} - {1'b0, win} + {1'b0, win & ~push};
  assign dsum = {1'b0, drop_cnt} + {31'd0, ndrop};
  assign {ev_type, ev_time, ev_pc, ev_data} = ev_valid ? mem[rd_q] : '0;
  assign ev_hart = ev_valid ? 8'(H) : 8'd0;
  // pick the lowest sampled lane, track the highest valid lane and count commits
  always_comb begin
    grad_c = 1'b0;
    gpc = '0;
    ginstr = '0;
    lpc = '0;
    linstr = '0;
    k = '0;
    for (int i = 0; i < W; i++) begin
      if (cmt_vld[i]) begin
        if (!grad_c && (((grad_cnt_q + k) & mask) == 32'd0)) begin
          grad_c = 1'b1;
          gpc = cmt_pc[64*i +: 64];
          ginstr = cmt_instr[32*i +: 32];
        end
        lpc = cmt_pc[64*i +: 64];
        linstr = cmt_instr[32*i +: 32];
        k = k + 32'd1;
      end
    end
  end
  // winning record: hang beats exception beats graduation
  always_comb begin
    win_rec = hang_c ? rec_t'({2'd2, cyc_q, last_pc_q, 32'd0, last_instr_q})
            : expt_c ? rec_t'({2'd1, cyc_q, expt_pc, expt_cause})
            : rec_t'({2'd0, cyc_q, gpc, 32'd0, ginstr});
  end
  // counters, hang level, last commit capture and FIFO bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
      hang_cnt_q <= '0;
      hang_o <= 1'b0;
      grad_cnt_q <= '0;
      last_pc_q <= '0;
      last_instr_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      drop_cnt <= '0;
    end else begin
      cyc_q <= cyc_q + 64'd1;
      hang_cnt_q <= act ? '0 : (&hang_cnt_q ? hang_cnt_q : hang_cnt_q + 32'd1);
      hang_o <= ~act & (cfg_hang != 32'd0) & (hang_cnt_q >= cfg_hang);
      grad_cnt_q <= grad_cnt_q + k;
      if (|cmt_vld) begin
        last_pc_q <= lpc;
        last_instr_q <= linstr;
      end
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      drop_cnt <= dsum[32] ? '1 : dsum[31:0];
    end
  end
  // record storage, no reset needed since reads are gated by the count
  always_ff @(posedge clock) begin
    if (push) mem[wr_q] <= win_rec;
  end
endmodule

// File: tb/tb_commit_mon.sv
// tb_commit_mon: directed scoreboard bench for commit_mon
module tb_commit_mon;
  localparam int W = 2;
  localparam int D = 4;
  localparam int H = 5;
  logic clock = 1'b0;
  logic reset_n;
  logic [31:0] cfg_hang;
  logic [4:0] cfg_grad;
  logic [63:0] cfg_xmask;
  logic [W-1:0] cmt_vld;
  logic [W*64-1:0] cmt_pc;
  logic [W*32-1:0] cmt_instr;
  logic wfi, expt_vld, ev_ready, ev_valid, hang_o;
  logic [63:0] expt_cause, expt_pc, ev_time, ev_pc, ev_data;
  logic [31:0] expt_instr, drop_cnt;
  logic [1:0] ev_type;
  logic [7:0] ev_hart;
  typedef struct {
    logic [1:0]  t;
    logic [63:0] tm;
    logic [63:0] pc;
    logic [63:0] data;
  } exp_t;
  exp_t q[$];
  int nvec = 0;
  int nerr = 0;
  int hcnt = 0;
  logic [63:0] tcyc = '0;

  commit_mon #(.W(W), .D(D), .H(H)) dut (
    .clock(clock), .reset_n(reset_n), .cfg_hang(cfg_hang), .cfg_grad(cfg_grad),
    .cfg_xmask(cfg_xmask), .cmt_vld(cmt_vld), .cmt_pc(cmt_pc), .cmt_instr(cmt_instr),
    .wfi(wfi), .expt_vld(expt_vld), .expt_cause(expt_cause), .expt_pc(expt_pc),
    .expt_instr(expt_instr), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .ev_hart(ev_hart), .ev_time(ev_time), .ev_pc(ev_pc), .ev_data(ev_data),
    .hang_o(hang_o), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_rec(input logic [1:0] t, input logic [63:0] pc, input logic [63:0] data);
    exp_t e;
    e.t = t;
    e.tm = tcyc;
    e.pc = pc;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    if (ev_valid && ev_ready) begin
      nvec++;
      assert (q.size() != 0) else begin
        nerr++;
        $error("FAIL unexpected_record observed_pc=%h expected=none", ev_pc);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("ev_type", 64'(ev_type), 64'(e.t));
        chk("ev_time", ev_time, e.tm);
        chk("ev_pc", ev_pc, e.pc);
        chk("ev_data", ev_data, e.data);
        chk("ev_hart", 64'(ev_hart), 64'(H));
      end
    end else if (!ev_valid) begin
      chk("idle_zero", ev_pc | ev_data | ev_time | 64'(ev_type) | 64'(ev_hart), 64'd0);
    end
    if (hang_o) hcnt++;
    @(posedge clock);
    #1;
    tcyc++;
  endtask

  initial begin
    reset_n = 1'b1;
    cfg_hang = '0;
    cfg_grad = '0;
    cfg_xmask = '0;
    cmt_vld = '0;
    cmt_pc = '0;
    cmt_instr = '0;
    wfi = 1'b0;
    expt_vld = 1'b0;
    expt_cause = '0;
    expt_pc = '0;
    expt_instr = '0;
    ev_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ev_valid", 64'(ev_valid), 64'd0);
    chk("rst_hang_o", 64'(hang_o), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tcyc = '0;
    // graduation sampling every 4 instructions, two lanes per cycle
    cfg_grad = 5'd2;
    cmt_vld = 2'b11;
    for (int n = 0; n < 4; n++) begin
      cmt_pc = {64'h8000_0000 + 64'(8*n + 4), 64'h8000_0000 + 64'(8*n)};
      cmt_instr = {32'h1000_0000 + 32'(2*n + 1), 32'h1000_0000 + 32'(2*n)};
      if (n % 2 == 0) expect_rec(2'd0, 64'h8000_0000 + 64'(8*n), 64'h1000_0000 + 64'(2*n));
      tick();
    end
    cmt_vld = '0;
    repeat (3) tick();
    chk("grad_drained", 64'(q.size()), 64'd0);
    // hang episode: one commit then 20 idle cycles
    cfg_grad = 5'd31;
    cfg_hang = 32'd10;
    cmt_vld = 2'b11;
    cmt_pc = {64'h1234, 64'h1230};
    cmt_instr = {32'habc, 32'hab0};
    hcnt = 0;
    tick();
    cmt_vld = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) expect_rec(2'd2, 64'h1234, 64'habc);
      tick();
    end
    wfi = 1'b1;
    repeat (2) tick();
    chk("hang_o_cycles", 64'(hcnt), 64'd10);
    chk("hang_o_fall", 64'(hang_o), 64'd0);
    chk("hang_drained", 64'(q.size()), 64'd0);
    // same idle period under wfi: no hang
    cmt_vld = 2'b01;
    cmt_pc = {64'h0, 64'h2000};
    cmt_instr = {32'h0, 32'h222};
    hcnt = 0;
    tick();
    cmt_vld = '0;
    repeat (20) tick();
    chk("wfi_no_hang", 64'(hcnt), 64'd0);
    // exception masking
    cfg_xmask = 64'h302;
    expt_vld = 1'b1;
    expt_pc = 64'h5000;
    expt_instr = 32'hdead;
    expt_cause = 64'd8;
    tick();
    expt_cause = 64'd2;
    expt_rec_wrap: begin
      expect_rec(2'd1, 64'h5000, 64'd2);
    end
    tick();
    expt_cause = 64'd72;
    expect_rec(2'd1, 64'h5000, 64'd72);
    tick();
    expt_cause = 64'd9;
    tick();
    expt_vld = 1'b0;
    repeat (2) tick();
    chk("expt_drained", 64'(q.size()), 64'd0);
    chk("expt_no_drop", 64'(drop_cnt), 64'd0);
    // hang and exception in the same cycle
    wfi = 1'b0;
    cfg_hang = 32'd3;
    repeat (3) tick();
    expt_vld = 1'b1;
    expt_cause = 64'd2;
    expt_pc = 64'h6000;
    expect_rec(2'd2, 64'h2000, 64'h222);
    tick();
    expt_vld = 1'b0;
    wfi = 1'b1;
    repeat (2) tick();
    chk("drop_hang_expt", 64'(drop_cnt), 64'd1);
    // exception and graduation in the same cycle
    cfg_hang = 32'd0;
    cfg_grad = 5'd0;
    cmt_vld = 2'b10;
    cmt_pc = {64'h7004, 64'h7000};
    cmt_instr = {32'h71, 32'h70};
    expt_vld = 1'b1;
    expt_cause = 64'd3;
    expt_pc = 64'h6100;
    expect_rec(2'd1, 64'h6100, 64'd3);
    tick();
    cmt_vld = '0;
    expt_vld = 1'b0;
    repeat (2) tick();
    chk("drop_expt_grad", 64'(drop_cnt), 64'd2);
    // lane offset k_i and lowest-lane selection
    cfg_grad = 5'd1;
    cmt_vld = 2'b01;
    cmt_pc = {64'h0, 64'h7100};
    cmt_instr = {32'h0, 32'h71};
    expect_rec(2'd0, 64'h7100, 64'h71);
    tick();
    cmt_vld = 2'b11;
    cmt_pc = {64'h7204, 64'h7200};
    cmt_instr = {32'h73, 32'h72};
    expect_rec(2'd0, 64'h7204, 64'h73);
    tick();
    cmt_vld = 2'b10;
    cmt_pc = {64'h7304, 64'h7300};
    tick();
    cfg_grad = 5'd0;
    cmt_vld = 2'b11;
    cmt_pc = {64'h7404, 64'h7400};
    cmt_instr = {32'h75, 32'h74};
    expect_rec(2'd0, 64'h7400, 64'h74);
    tick();
    cmt_vld = '0;
    repeat (2) tick();
    chk("lane_drained", 64'(q.size()), 64'd0);
    // overflow with the consumer stalled
    ev_ready = 1'b0;
    cmt_vld = 2'b01;
    for (int n = 0; n < 6; n++) begin
      cmt_pc = {64'h0, 64'h9000 + 64'(4*n)};
      cmt_instr = {32'h0, 32'h90 + 32'(n)};
      if (n < 4) expect_rec(2'd0, 64'h9000 + 64'(4*n), 64'h90 + 64'(n));
      tick();
    end
    cmt_vld = '0;
    tick();
    chk("full_valid", 64'(ev_valid), 64'd1);
    chk("full_drop", 64'(drop_cnt), 64'd4);
    chk("stall_head", ev_pc, 64'h9000);
    tick();
    chk("stall_head_hold", ev_pc, 64'h9000);
    ev_ready = 1'b1;
    cmt_vld = 2'b01;
    cmt_pc = {64'h0, 64'hA000};
    cmt_instr = {32'h0, 32'ha0};
    tick();
    cmt_pc = {64'h0, 64'hA004};
    cmt_instr = {32'h0, 32'ha4};
    expect_rec(2'd0, 64'hA004, 64'ha4);
    tick();
    cmt_vld = '0;
    repeat (3) tick();
    chk("drain_per_cycle", 64'(q.size()), 64'd0);
    chk("full_pop_drop", 64'(drop_cnt), 64'd5);
    chk("drain_empty", 64'(ev_valid), 64'd0);
    // asynchronous reset with records held
    ev_ready = 1'b0;
    cmt_vld = 2'b01;
    for (int n = 0; n < 3; n++) begin
      cmt_pc = {64'h0, 64'hB000 + 64'(4*n)};
      tick();
    end
    cmt_vld = '0;
    tick();
    chk("pre_rst_valid", 64'(ev_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(ev_valid), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    chk("mid_rst_pc", ev_pc, 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tcyc = '0;
    ev_ready = 1'b1;
    cmt_vld = 2'b01;
    cmt_pc = {64'h0, 64'hC000};
    cmt_instr = {32'h0, 32'hc0};
    expect_rec(2'd0, 64'hC000, 64'hc0);
    tick();
    cmt_vld = '0;
    repeat (2) tick();
    chk("post_rst_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
